countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning clock cycles per one-second tick.
REQ-002 SHALL have parameter START_MINUTES, default 5, meaning the load value of the minutes digit (legal range 0-9), with seconds loaded as 00.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock, all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flag, input, 1 bit: 1 = count down, 0 = paused.
REQ-006 SHALL have port SegMins, output, 7 bits: minutes digit, seven-segment.
REQ-007 SHALL have port SegSecTens, output, 7 bits: seconds-tens digit (0-5), seven-segment.
REQ-008 SHALL have port SegSecUnits, output, 7 bits: seconds-units digit (0-9), seven-segment.
REQ-009 SHALL have port Timeout, output, 1 bit: high when the count has reached 0:00.

Function
REQ-010 SHALL keep a prescaler counting 0..CLOCK_FREQ-1; it advances only while flag=1 and Timeout=0, and holds its value while paused.
REQ-011 SHALL generate a one-cycle tick when the prescaler wraps from CLOCK_FREQ-1 to 0.
REQ-012 SHALL decrement the M:ST:SU BCD time by one second on each tick, updating registers on the same clock edge as the tick.
REQ-013 SHALL borrow as follows: SU 0 -> 9 with ST-1; ST 0 -> 5 with M-1; SU and ST both 0 -> SU=9, ST=5, M-1.
REQ-014 SHALL, once the time equals 0:00, assert Timeout and hold all counters frozen until reset; there is no wrap below zero.
REQ-015 SHALL derive Timeout combinationally from time==0:00, so START_MINUTES=0 asserts Timeout immediately after reset.
REQ-016 SHALL make the pause lossless: flag 1->0->1 resumes from the exact prescaler phase.
REQ-017 SHALL make each segment output combinational from its digit register, active-low, with bit order {g,f,e,d,c,b,a}.
REQ-018 SHALL encode 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 SHALL blank any non-BCD digit value (1111111).
REQ-020 SHALL give flag no effect while reset is asserted.

Reset
REQ-021 SHALL, while reset=0, asynchronously set M=START_MINUTES, ST=0, SU=0, prescaler=0.
REQ-022 SHALL, during reset with defaults, drive SegMins=0010010, SegSecTens=SegSecUnits=1000000, Timeout=0.
REQ-023 SHALL, on reset assertion mid-count or mid-pause, abort the count immediately; counting resumes after release only when flag=1.
REQ-024 SHALL not synchronise reset internally; the requirement is met when a release aligned to a clock edge is tolerated.

Structure
REQ-025 SHALL place the shared package contents, namely the seven-segment constant table (SEG_0..SEG_9, SEG_BLANK) and the 4-bit BCD digit typedef.
REQ-026 SHALL use one sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low out), instantiated three times.
REQ-027 SHALL size the prescaler width as $clog2(CLOCK_FREQ).

Verification (bench uses CLOCK_FREQ=10, START_MINUTES=1, 20 ns clock)
REQ-028 SHALL cover reset low 50 ns, then reset high with flag=0 for 1 µs -> display stays 1:00, Timeout=0.
REQ-029 SHALL cover flag=1 for 10 clocks -> display 0:59 (SegSecTens=0010010, SegSecUnits=0010000).
REQ-030 SHALL cover flag=1 for 5 clocks, flag=0 for 100 clocks, flag=1 for 5 clocks -> exactly one decrement, total 10 counting clocks.
REQ-031 SHALL cover flag=1 for 600 clocks -> 0:00 with Timeout=1, and a further 100 clocks leave outputs unchanged.
REQ-032 SHALL cover the 0:50 -> 0:49 and 1:00 -> 0:59 borrow boundaries -> digits exactly as in REQ-013.
REQ-033 SHALL cover reset=0 mid-count at 0:37 -> immediate 1:00 with Timeout=0, independent of clock.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and seven-segment constants for the M:SS countdown timer.
// Segment patterns are active-low with bit order {g,f,e,d,c,b,a}.
package countdown_timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam bcd_t BCD_NINE = 4'd9;
    localparam bcd_t BCD_FIVE = 4'd5;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; any value above 9
// shows a blank digit.
module seg7_decoder
    import countdown_timer_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_timer.sv
// M:ST:SU BCD countdown timer with a one-second prescaler, pause input and
// a sticky Timeout at 0:00; reset is asynchronous and active-low.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int START_MINUTES = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flag,
    output logic [6:0] SegMins,
    output logic [6:0] SegSecTens,
    output logic [6:0] SegSecUnits,
    output logic       Timeout
);

    localparam int             PW         = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLOCK_FREQ - 1);
    localparam bcd_t           START_M    = bcd_t'(START_MINUTES);

    logic [PW-1:0] presc_q, presc_d;
    bcd_t          mins_q, mins_d;
    bcd_t          sec_tens_q, sec_tens_d;
    bcd_t          sec_units_q, sec_units_d;
    logic          run;
    logic          tick;

    // Once the time reaches 0:00 the prescaler stops too, so nothing moves.
    assign Timeout = (mins_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_units_q == 4'd0);
    assign run     = flag && !Timeout;
    assign tick    = run && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        if (run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        mins_d      = mins_q;
        sec_tens_d  = sec_tens_q;
        sec_units_d = sec_units_q;
        if (tick) begin
            if (sec_units_q != 4'd0) begin
                sec_units_d = sec_units_q - 4'd1;
            end else begin
                sec_units_d = BCD_NINE;
                if (sec_tens_q != 4'd0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                end else begin
                    sec_tens_d = BCD_FIVE;
                    mins_d     = mins_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            mins_q      <= START_M;
            sec_tens_q  <= 4'd0;
            sec_units_q <= 4'd0;
        end else begin
            presc_q     <= presc_d;
            mins_q      <= mins_d;
            sec_tens_q  <= sec_tens_d;
            sec_units_q <= sec_units_d;
        end
    end

    seg7_decoder u_dec_mins (
        .digit (mins_q),
        .seg   (SegMins)
    );

    seg7_decoder u_dec_sec_tens (
        .digit (sec_tens_q),
        .seg   (SegSecTens)
    );

    seg7_decoder u_dec_sec_units (
        .digit (sec_units_q),
        .seg   (SegSecUnits)
    );

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed phases plus random pause patterns,
// checked against a seconds-remaining reference model.
module tb_countdown_timer;
    import countdown_timer_pkg::*;

    localparam int CF  = 10;
    localparam int STM = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       flag  = 1'b0;
    logic [6:0] seg_m, seg_st, seg_su;
    logic       timeout;
    logic [6:0] seg_m0, seg_st0, seg_su0;
    logic       timeout0;
    bcd_t       dec_in;
    logic [6:0] dec_out;

    int errors = 0;
    int checks = 0;

    // Reference model: whole seconds remaining plus clocks into the current second.
    int rem   = 60 * STM;
    int phase = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    always #10 clock = ~clock;

    countdown_timer #(.CLOCK_FREQ(CF), .START_MINUTES(STM)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .flag        (flag),
        .SegMins     (seg_m),
        .SegSecTens  (seg_st),
        .SegSecUnits (seg_su),
        .Timeout     (timeout)
    );

    countdown_timer #(.CLOCK_FREQ(CF), .START_MINUTES(0)) u_dut_zero (
        .clock       (clock),
        .reset       (reset),
        .flag        (flag),
        .SegMins     (seg_m0),
        .SegSecTens  (seg_st0),
        .SegSecUnits (seg_su0),
        .Timeout     (timeout0)
    );

    seg7_decoder u_dec (
        .digit (dec_in),
        .seg   (dec_out)
    );

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem   = 60 * STM;
            phase = 0;
        end else if (flag && rem > 0) begin
            phase = phase + 1;
            if (phase == CF) begin
                phase = 0;
                rem   = rem - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_min"},   32'(seg_m),   32'(seg_tab[rem / 60]));
        check({tag, "_tens"},  32'(seg_st),  32'(seg_tab[(rem % 60) / 10]));
        check({tag, "_units"}, 32'(seg_su),  32'(seg_tab[rem % 10]));
        check({tag, "_tmo"},   32'(timeout), 32'(rem == 0));
    endtask

    task automatic check_time(input string tag, input logic [6:0] m, input logic [6:0] st,
                              input logic [6:0] su, input logic tmo);
        check({tag, "_min_c"},   32'(seg_m),   32'(m));
        check({tag, "_tens_c"},  32'(seg_st),  32'(st));
        check({tag, "_units_c"}, 32'(seg_su),  32'(su));
        check({tag, "_tmo_c"},   32'(timeout), 32'(tmo));
    endtask

    task automatic run_clocks(input int n, input logic f);
        flag = f;
        repeat (n) @(negedge clock);
    endtask

    task automatic run_checked(input int n, input logic f, input string tag);
        flag = f;
        repeat (n) begin
            @(negedge clock);
            check_model(tag);
        end
    endtask

    initial begin
        // Reset state and the START_MINUTES=0 instance.
        #50;
        check_time("reset", SEG_1, SEG_0, SEG_0, 1'b0);
        check("zero_tmo_in_reset", 32'(timeout0), 32'd1);
        check("zero_min_in_reset", 32'(seg_m0), 32'(SEG_0));
        @(negedge clock);
        reset = 1'b1;

        // Paused for 1 us: display must hold.
        run_checked(50, 1'b0, "paused");
        check_time("paused_end", SEG_1, SEG_0, SEG_0, 1'b0);

        // Ten counting clocks: 1:00 -> 0:59.
        run_clocks(9, 1'b1);
        check_time("before_first_tick", SEG_1, SEG_0, SEG_0, 1'b0);
        run_clocks(1, 1'b1);
        check_time("first_tick", SEG_0, SEG_5, SEG_9, 1'b0);
        check_model("first_tick_m");

        // Lossless pause: 5 + (100 paused) + 5 counting clocks is one second.
        run_clocks(5, 1'b1);
        run_checked(100, 1'b0, "mid_pause");
        run_clocks(4, 1'b1);
        check_time("resume_not_yet", SEG_0, SEG_5, SEG_9, 1'b0);
        run_clocks(1, 1'b1);
        check_time("resume_tick", SEG_0, SEG_5, SEG_8, 1'b0);

        // Tens borrow: 0:50 -> 0:49.
        run_clocks(80, 1'b1);
        check_time("at_0_50", SEG_0, SEG_5, SEG_0, 1'b0);
        run_clocks(10, 1'b1);
        check_time("at_0_49", SEG_0, SEG_4, SEG_9, 1'b0);

        // Reach 0:37 half way through a second, then reset between clock edges.
        run_clocks(125, 1'b1);
        check_time("at_0_37", SEG_0, SEG_3, SEG_7, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check_time("async_reset", SEG_1, SEG_0, SEG_0, 1'b0);
        run_clocks(5, 1'b1);
        check_time("flag_in_reset", SEG_1, SEG_0, SEG_0, 1'b0);
        flag  = 1'b0;
        reset = 1'b1;
        run_checked(20, 1'b0, "after_reset_paused");

        // Random run/pause pattern against the model.
        for (int i = 0; i < 30; i++) begin
            run_checked($urandom_range(1, 40), 1'($urandom_range(0, 1)), "random");
        end

        // Count to zero and confirm everything freezes.
        run_clocks(600, 1'b1);
        check_time("timeout", SEG_0, SEG_0, SEG_0, 1'b1);
        check_model("timeout_m");
        for (int i = 0; i < 100; i++) begin
            flag = 1'($urandom_range(0, 1));
            @(negedge clock);
            check_time("frozen", SEG_0, SEG_0, SEG_0, 1'b1);
        end
        check("zero_tmo_running", 32'(timeout0), 32'd1);

        // Decoder table including the blanked non-BCD codes.
        for (int v = 0; v < 16; v++) begin
            dec_in = bcd_t'(v);
            #1;
            check($sformatf("decode_%0d", v), 32'(dec_out),
                  32'((v < 10) ? seg_tab[v] : SEG_BLANK));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
